fetch_queue: RTL and testbench

- Parametrised successor to the single-slot fetch stage and fetch register pair.
- Decouples instruction fetch from decode with a DEPTH-entry queue of {pc, instr}.
- Drives the instruction bus with at most one request outstanding.
- Handles redirects (branch/jump from decode or execute) by flushing the queue and discarding any in-flight response.
- Sits between the ibus and the decode stage inside core, replacing the fetch, fetch-register and PC-register trio.

---
 rtl/fetch_queue_if.sv | 38 +++
 rtl/fetch_queue.sv | 105 ++++++++++
 tb/tb_fetch_queue.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Bundles the instruction-bus handshake and the decode-side queue port of fetch_queue.
// The master modport is the fetch queue; the slave modport is the bus plus decode side.
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int ILEN  = 32
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic            addr_ok;
        logic            data_ok;
        logic [ILEN-1:0] data;
    } ibus_resp_t;

    ibus_req_t              ireq;
    ibus_resp_t             iresp;
    logic                   redirect_valid;
    logic [XLEN-1:0]        redirect_pc;
    logic                   out_valid;
    logic [XLEN-1:0]        out_pc;
    logic [ILEN-1:0]        out_instr;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] occupancy;

    modport master (
        output ireq, out_valid, out_pc, out_instr, occupancy,
        input  iresp, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  ireq, out_valid, out_pc, out_instr, occupancy,
        output iresp, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch queue: one ibus request in flight, DEPTH-entry {pc, instr} FIFO.
// Latency: entry visible 1 cycle after data_ok.
// Backpressure: no request is issued unless a slot is free after this cycle's pop; redirect flushes and drains.
module fetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_queue_if.master bus
);
    localparam int              PW   = $clog2(DEPTH);
    localparam int              OW   = PW + 1;
    localparam logic [OW-1:0]   FULL = OW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] req_addr;
    logic [PW-1:0]   head, tail;
    logic [OW-1:0]   occ, occ_after_pop;
    logic            push, pop, issue;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];

    logic unused_addr_ok;
    assign unused_addr_ok = bus.iresp.addr_ok;

    always_comb begin
        state_nxt     = state;
        issue         = 1'b0;
        pop           = (occ != '0) && bus.out_ready;
        push          = (state == REQ) && bus.iresp.data_ok && !bus.redirect_valid;
        occ_after_pop = occ - OW'(pop);
        case (state)
            IDLE: begin
                if (!bus.redirect_valid && (occ_after_pop < FULL)) begin
                    state_nxt = REQ;
                    issue     = 1'b1;
                end
            end
            REQ: begin
                // A redirect landing with data_ok just drops the data; nothing left to drain.
                if (bus.iresp.data_ok)
                    state_nxt = IDLE;
                else if (bus.redirect_valid)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (bus.iresp.data_ok)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // req_addr is captured at issue so the bus address stays put while fpc is redirected.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            fpc      <= RESET_PC;
            req_addr <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
        end else begin
            state <= state_nxt;
            if (issue)
                req_addr <= fpc;
            if (bus.redirect_valid)
                fpc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            else if (push)
                fpc <= fpc + XLEN'(4);
            if (bus.redirect_valid) begin
                head <= tail;
                occ  <= '0;
            end else begin
                if (push)
                    tail <= tail + PW'(1);
                if (pop)
                    head <= head + PW'(1);
                occ <= occ_after_pop + OW'(push);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            pc_mem[tail]    <= fpc;
            instr_mem[tail] <= bus.iresp.data;
        end
    end

    assign bus.ireq      = {(state != IDLE), req_addr};
    assign bus.out_valid = (occ != '0);
    assign bus.out_pc    = pc_mem[head];
    assign bus.out_instr = instr_mem[head];
    assign bus.occupancy = occ;

    push_into_full: assert property (@(posedge clk) disable iff (!reset) !(push && (occ == FULL)));
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a DEPTH=4 and a DEPTH=2 instance share clock and reset.
module tb_fetch_queue;
    localparam logic [63:0] RPC = 64'h8000_0000;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t sb[$];

    fetch_queue_if #(.DEPTH(4), .XLEN(64), .ILEN(32)) bus4 ();
    fetch_queue_if #(.DEPTH(2), .XLEN(64), .ILEN(32)) bus2 ();

    fetch_queue #(.DEPTH(4), .XLEN(64), .ILEN(32), .RESET_PC(RPC)) u_dut4 (
        .clk(clk), .reset(reset), .bus(bus4.master)
    );
    fetch_queue #(.DEPTH(2), .XLEN(64), .ILEN(32), .RESET_PC(RPC)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9bdf;
    endfunction

    task automatic idle_inputs();
        bus4.iresp = '0; bus4.redirect_valid = 1'b0; bus4.redirect_pc = '0; bus4.out_ready = 1'b0;
        bus2.iresp = '0; bus2.redirect_valid = 1'b0; bus2.redirect_pc = '0; bus2.out_ready = 1'b0;
    endtask

    // Leaves the bench at a negedge with reset just released; the next posedge enters REQ.
    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        tests++; if (bus4.ireq.valid !== 1'b0) begin fails++; $display("FAIL reset_ireq_valid got %0b want 0", bus4.ireq.valid); end
        tests++; if (bus4.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", bus4.out_valid); end
        tests++; if (bus4.occupancy !== 3'd0) begin fails++; $display("FAIL reset_occupancy got %0d want 0", bus4.occupancy); end
        reset = 1'b1;
        @(negedge clk);
        tests++; if (bus4.ireq.valid !== 1'b1 || bus4.ireq.addr !== RPC) begin
            fails++; $display("FAIL reset_first_req got v=%0b a=%h want v=1 a=%h", bus4.ireq.valid, bus4.ireq.addr, RPC);
        end
    endtask

    task automatic test_stream();
        logic [63:0] exp_addr;
        int          nreq;
        logic        resp_prev;
        ent_t        e;
        do_reset();
        bus4.out_ready = 1'b1;
        exp_addr = RPC; nreq = 0; resp_prev = 1'b0;
        for (int c = 0; c < 60 && !(nreq >= 6 && sb.size() == 0); c++) begin
            @(negedge clk);
            bus4.iresp.data_ok = 1'b0;
            if (resp_prev) begin
                tests++; if (bus4.out_valid !== 1'b1) begin fails++; $display("FAIL stream_visible got out_valid=%0b want 1", bus4.out_valid); end
            end
            resp_prev = 1'b0;
            if (bus4.out_valid) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL stream_pop unexpected entry pc=%h", bus4.out_pc);
                end else begin
                    e = sb.pop_front();
                    if (bus4.out_pc !== e.pc || bus4.out_instr !== e.instr) begin
                        fails++; $display("FAIL stream_pop got %h/%h want %h/%h", bus4.out_pc, bus4.out_instr, e.pc, e.instr);
                    end
                end
            end
            tests++; if (bus4.occupancy > 3'd1 || $isunknown(bus4.occupancy)) begin
                fails++; $display("FAIL stream_occupancy got %0d want <=1", bus4.occupancy);
            end
            if (bus4.ireq.valid && nreq < 6) begin
                tests++; if (bus4.ireq.addr !== exp_addr) begin fails++; $display("FAIL stream_addr got %h want %h", bus4.ireq.addr, exp_addr); end
                bus4.iresp.data_ok = 1'b1;
                bus4.iresp.data    = instr_of(exp_addr);
                sb.push_back('{exp_addr, instr_of(exp_addr)});
                exp_addr += 64'd4;
                nreq++;
                resp_prev = 1'b1;
            end
        end
        tests++; if (nreq != 6 || sb.size() != 0) begin fails++; $display("FAIL stream_done got req=%0d left=%0d want 6/0", nreq, sb.size()); end
    endtask

    task automatic test_full();
        logic [63:0] exp_addr;
        int          cnt;
        ent_t        e;
        do_reset();
        exp_addr = RPC;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus4.iresp.data_ok = 1'b0;
            if (bus4.occupancy == 3'd4) break;
            if (bus4.ireq.valid) begin
                tests++; if (bus4.ireq.addr !== exp_addr) begin fails++; $display("FAIL full_addr got %h want %h", bus4.ireq.addr, exp_addr); end
                bus4.iresp.data_ok = 1'b1;
                bus4.iresp.data    = instr_of(exp_addr);
                sb.push_back('{exp_addr, instr_of(exp_addr)});
                exp_addr += 64'd4;
            end
        end
        tests++; if (bus4.occupancy !== 3'd4) begin fails++; $display("FAIL full_fill got %0d want 4", bus4.occupancy); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++; if (bus4.ireq.valid !== 1'b0) begin fails++; $display("FAIL full_no_req got valid=%0b want 0", bus4.ireq.valid); end
        end
        @(negedge clk);
        bus4.out_ready = 1'b1;
        tests++;
        if (sb.size() == 0) begin
            fails++; $display("FAIL full_head scoreboard empty, dut pc=%h", bus4.out_pc);
        end else begin
            e = sb.pop_front();
            if (bus4.out_pc !== e.pc || bus4.out_instr !== e.instr) begin
                fails++; $display("FAIL full_head got %h/%h want %h/%h", bus4.out_pc, bus4.out_instr, e.pc, e.instr);
            end
        end
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus4.out_ready = 1'b0;
            bus4.iresp.data_ok = 1'b0;
            if (bus4.ireq.valid) begin
                cnt++;
                tests++; if (bus4.ireq.addr !== RPC + 64'h10) begin fails++; $display("FAIL full_refill_addr got %h want %h", bus4.ireq.addr, RPC + 64'h10); end
                bus4.iresp.data_ok = 1'b1;
                bus4.iresp.data    = instr_of(bus4.ireq.addr);
            end
        end
        tests++; if (cnt != 1) begin fails++; $display("FAIL full_one_req got %0d requests want 1", cnt); end
        tests++; if (bus4.occupancy !== 3'd4) begin fails++; $display("FAIL full_refill_occ got %0d want 4", bus4.occupancy); end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        @(negedge clk);
        bus4.iresp.data_ok = 1'b1; bus4.iresp.data = instr_of(RPC);
        @(negedge clk);
        bus4.iresp.data_ok = 1'b0;
        @(negedge clk);
        tests++; if (bus4.ireq.valid !== 1'b1 || bus4.ireq.addr !== RPC + 64'd4) begin
            fails++; $display("FAIL redir_pre_req got v=%0b a=%h want 1/%h", bus4.ireq.valid, bus4.ireq.addr, RPC + 64'd4);
        end
        bus4.redirect_valid = 1'b1; bus4.redirect_pc = 64'h8000_0100;
        @(negedge clk);
        bus4.redirect_valid = 1'b0;
        tests++; if (bus4.occupancy !== 3'd0 || bus4.out_valid !== 1'b0) begin
            fails++; $display("FAIL redir_flush got occ=%0d ov=%0b want 0/0", bus4.occupancy, bus4.out_valid);
        end
        for (int c = 0; c < 2; c++) begin
            tests++; if (bus4.ireq.valid !== 1'b1 || bus4.ireq.addr !== RPC + 64'd4) begin
                fails++; $display("FAIL redir_hold_addr got v=%0b a=%h want 1/%h", bus4.ireq.valid, bus4.ireq.addr, RPC + 64'd4);
            end
            @(negedge clk);
        end
        bus4.iresp.data_ok = 1'b1; bus4.iresp.data = 32'hdead_beef;
        @(negedge clk);
        bus4.iresp.data_ok = 1'b0;
        tests++; if (bus4.occupancy !== 3'd0 || bus4.ireq.valid !== 1'b0) begin
            fails++; $display("FAIL redir_discard got occ=%0d v=%0b want 0/0", bus4.occupancy, bus4.ireq.valid);
        end
        @(negedge clk);
        tests++; if (bus4.ireq.valid !== 1'b1 || bus4.ireq.addr !== 64'h8000_0100) begin
            fails++; $display("FAIL redir_target got v=%0b a=%h want 1/80000100", bus4.ireq.valid, bus4.ireq.addr);
        end
        bus4.iresp.data_ok = 1'b1; bus4.iresp.data = instr_of(64'h8000_0100);
        @(negedge clk);
        bus4.iresp.data_ok = 1'b0;
        tests++; if (bus4.occupancy !== 3'd1 || bus4.out_pc !== 64'h8000_0100 || bus4.out_instr !== instr_of(64'h8000_0100)) begin
            fails++; $display("FAIL redir_push got occ=%0d pc=%h i=%h want 1/80000100/%h", bus4.occupancy, bus4.out_pc, bus4.out_instr, instr_of(64'h8000_0100));
        end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        bus4.out_ready = 1'b1;
        @(negedge clk);
        tests++; if (bus4.ireq.valid !== 1'b1 || bus4.ireq.addr !== RPC) begin
            fails++; $display("FAIL same_req got v=%0b a=%h want 1/%h", bus4.ireq.valid, bus4.ireq.addr, RPC);
        end
        bus4.iresp.data_ok = 1'b1; bus4.iresp.data = 32'h1234_5678;
        bus4.redirect_valid = 1'b1; bus4.redirect_pc = 64'h8000_0203;
        @(negedge clk);
        bus4.iresp.data_ok = 1'b0; bus4.redirect_valid = 1'b0;
        tests++; if (bus4.occupancy !== 3'd0 || bus4.out_valid !== 1'b0 || bus4.ireq.valid !== 1'b0) begin
            fails++; $display("FAIL same_no_push got occ=%0d ov=%0b v=%0b want 0/0/0", bus4.occupancy, bus4.out_valid, bus4.ireq.valid);
        end
        @(negedge clk);
        tests++; if (bus4.ireq.valid !== 1'b1 || bus4.ireq.addr !== 64'h8000_0200) begin
            fails++; $display("FAIL same_target got v=%0b a=%h want 1/80000200", bus4.ireq.valid, bus4.ireq.addr);
        end
    endtask

    task automatic test_depth2();
        logic [63:0] exp_addr;
        int          npush;
        int          nsim;
        logic        ready;
        ent_t        e;
        do_reset();
        exp_addr = RPC; npush = 0; nsim = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            bus2.iresp.data_ok = 1'b0;
            if (npush == 6 && sb.size() == 0) break;
            ready = (npush == 6) || ((npush >= 2) && (bus2.ireq.valid || bus2.occupancy == 2'd2));
            bus2.out_ready = ready;
            tests++; if (bus2.occupancy > 2'd2 || $isunknown(bus2.occupancy)) begin
                fails++; $display("FAIL d2_occupancy got %0d want <=2", bus2.occupancy);
            end
            if (ready && bus2.out_valid) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL d2_pop unexpected entry pc=%h", bus2.out_pc);
                end else begin
                    e = sb.pop_front();
                    if (bus2.out_pc !== e.pc || bus2.out_instr !== e.instr) begin
                        fails++; $display("FAIL d2_pop got %h/%h want %h/%h", bus2.out_pc, bus2.out_instr, e.pc, e.instr);
                    end
                end
            end
            if (bus2.ireq.valid && npush < 6) begin
                if (ready && bus2.out_valid) nsim++;
                tests++; if (bus2.ireq.addr !== exp_addr) begin fails++; $display("FAIL d2_addr got %h want %h", bus2.ireq.addr, exp_addr); end
                bus2.iresp.data_ok = 1'b1;
                bus2.iresp.data    = instr_of(exp_addr);
                sb.push_back('{exp_addr, instr_of(exp_addr)});
                exp_addr += 64'd4;
                npush++;
            end
        end
        bus2.out_ready = 1'b0;
        tests++; if (npush != 6 || sb.size() != 0 || bus2.occupancy !== 2'd0) begin
            fails++; $display("FAIL d2_done got push=%0d left=%0d occ=%0d want 6/0/0", npush, sb.size(), bus2.occupancy);
        end
        tests++; if (nsim < 2) begin fails++; $display("FAIL d2_simultaneous got %0d want >=2", nsim); end
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        @(negedge clk);
        bus4.iresp.data_ok = 1'b1; bus4.iresp.data = instr_of(RPC);
        @(negedge clk);
        bus4.iresp.data_ok = 1'b0;
        @(negedge clk);
        bus4.redirect_valid = 1'b1; bus4.redirect_pc = 64'h8000_0300;
        @(negedge clk);
        bus4.redirect_valid = 1'b0;
        tests++; if (bus4.ireq.valid !== 1'b1 || bus4.ireq.addr !== RPC + 64'd4) begin
            fails++; $display("FAIL drain_state got v=%0b a=%h want 1/%h", bus4.ireq.valid, bus4.ireq.addr, RPC + 64'd4);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++; if (bus4.ireq.valid !== 1'b0 || bus4.out_valid !== 1'b0 || bus4.occupancy !== 3'd0) begin
            fails++; $display("FAIL drain_reset got v=%0b ov=%0b occ=%0d want 0/0/0", bus4.ireq.valid, bus4.out_valid, bus4.occupancy);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++; if (bus4.ireq.valid !== 1'b1 || bus4.ireq.addr !== RPC) begin
            fails++; $display("FAIL drain_restart got v=%0b a=%h want 1/%h", bus4.ireq.valid, bus4.ireq.addr, RPC);
        end
        bus4.iresp.data_ok = 1'b1; bus4.iresp.data = instr_of(RPC);
        @(negedge clk);
        bus4.iresp.data_ok = 1'b0;
        tests++; if (bus4.occupancy !== 3'd1 || bus4.out_pc !== RPC) begin
            fails++; $display("FAIL drain_first_push got occ=%0d pc=%h want 1/%h", bus4.occupancy, bus4.out_pc, RPC);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_stream();
        test_full();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_depth2();
        test_reset_in_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
